nic_width_fifo: RTL
===================

# nic_width_fifo

Synchronous buffer between the AXI4-lite slave interface and the NoC router port. It accepts 64-bit packets (address in bits 63:32, payload in bits 31:0) on a push strobe. It returns them as two 32-bit words on the pop side: the address word first, then the payload word. A packet's slot is freed only after both words are popped.

## Interface
Parameters:
- DEPTH, 8: number of 64-bit entries; power of two, minimum 2.
- AW, $clog2(DEPTH): pointer index width; derived, not overridden.

Ports:
- aclk, input, 1: clock; all logic on rising edge.
- reset, input, 1: reset, synchronous, active-high; clock aclk.
- write_en, input, 1: push strobe; one packet per cycle while high.
- write_data, input, 64: packet {address[31:0], payload[31:0]}.
- full, output, 1: high when DEPTH packets are stored.
- read_en, input, 1: pop strobe; one 32-bit word per cycle while high.
- read_data, output, 32: current head word, first-word-fall-through.
- empty, output, 1: high when no packet is stored.
- level, output, AW+1: number of stored packets, 0..DEPTH.
- overflow, output, 1: sticky push-while-full flag (NIC_FIFO_ERR_EN only).
- underflow, output, 1: sticky pop-while-empty flag (NIC_FIFO_ERR_EN only).

## Operation
- Storage: DEPTH x 64 array, not reset.
- Pointers: wr_ptr and rd_ptr are AW+1 bits; the MSB is the wrap bit. Both increment modulo 2^(AW+1).
- Occupancy: level = wr_ptr - rd_ptr (AW+1 bit subtraction).
  - empty = (level == 0).
  - full = (level == DEPTH).
- Half select register hsel:
  - hsel = 0: the next pop returns the address word, mem[rd][63:32].
  - hsel = 1: the next pop returns the payload word, mem[rd][31:0].
- Push (write_en && !full):
  - mem[wr_ptr[AW-1:0]] <= write_data.
  - wr_ptr <= wr_ptr + 1.
- Push while full: ignored; data is dropped and no state changes, except overflow.
- Pop (read_en && !empty):
  - If hsel = 0: hsel <= 1.
  - If hsel = 1: hsel <= 0 and rd_ptr <= rd_ptr + 1.
- Pop while empty: ignored, except underflow.
- read_data:
  - Combinational mux of the head entry by hsel.
  - Forced to 32'h0 while empty.
- Simultaneous push and pop:
  - Both are evaluated against the pre-edge full/empty.
  - No bypass: a push into an empty FIFO is not poppable in the same cycle.
  - A push while full is rejected even if the same edge completes a packet pop.
- Reset values: wr_ptr = 0, rd_ptr = 0, hsel = 0, empty = 1, full = 0, level = 0, read_data = 0, overflow = 0, underflow = 0.
- Reset mid-packet (hsel = 1) discards the half-read packet and all stored packets.

## Timing
- Push-to-visible latency:
  - Push at edge N: empty falls after edge N.
  - The address word is on read_data during cycle N+1.
- Pop: read_data advances to the next word one cycle after the pop edge.
- A full two-word pop takes 2 cycles. Back-to-back pops drain at 1 word/cycle.
- full and level update on the edge that completes the second-word pop, not the first.
- full, empty and level are pure functions of registers; there is no combinational path from write_en or read_en.
- Sustained throughput: 1 push per 2 cycles under continuous pop.

## Configuration
- Macro: NIC_FIFO_ERR_EN.
- When defined:
  - overflow and underflow ports exist.
  - overflow sets on write_en && full; underflow sets on read_en && empty.
  - Both are sticky until reset.
- When undefined:
  - The ports and their registers are absent.
  - Illegal pushes and pops are silently ignored.
- The data path is identical in both builds.

## Test plan
- Single packet: push 64'hA000_0004_1234_5678, then pop twice. read_data shows 32'hA000_0004, then 32'h1234_5678. empty rises after the 2nd pop; level goes 1 -> 0.
- Fill: push 8 packets with DEPTH=8. full = 1 and level = 8. A 9th push 64'hDEAD is dropped and overflow = 1 (ERR build). Drain 16 pops returns the first 8 packets in order.
- Partial pop with full: when full, one pop leaves full = 1 (hsel = 1). The second pop clears full. A push on that same edge is rejected.
- Concurrency and wrap: 20 packets streamed with interleaved push/pop over DEPTH=8 (pointer wrap). Output order and word order are preserved, with no lost or duplicated words.
- Empty pop: read_en while empty leaves state unchanged, read_data = 0, underflow = 1 (ERR build).
- Reset mid-packet: push 2 packets, pop 1 word, assert reset one cycle. Then empty = 1, level = 0, read_data = 0, hsel = 0. A fresh push reads out its address word first.

Source files
------------

// File: rtl/nic_width_fifo.sv
// ---------------------------------------------------------------------------
// nic_width_fifo
//
// Buffer between the AXI4-lite slave side and the NoC router port. Packets
// enter 64 bits wide ({address, payload}) and leave as two 32-bit words:
// the address word first, then the payload word. A packet's slot is released
// only once its second word has been popped.
//
// Optional build macro: NIC_FIFO_ERR_EN adds the sticky overflow/underflow
// flags. The data path is the same with or without it.
//
// Handshake: write_en and read_en are strobes, not requests that wait.
// full acts as the push-side "not ready" and empty as the pop-side
// "not valid". A push is taken on a rising edge where write_en is high and
// full is low. A pop is taken on a rising edge where read_en is high and
// empty is low. Any other strobe is dropped and leaves the FIFO unchanged.
// Both decisions use the register state from before the edge, so there is
// no bypass and no combinational path from a strobe to full/empty/level.
//
// Ports:
//   aclk        clock, rising edge
//   reset       synchronous, active-high
//   write_en    push strobe, one packet per cycle
//   write_data  packet {address[31:0], payload[31:0]}
//   full        DEPTH packets stored
//   read_en     pop strobe, one 32-bit word per cycle
//   read_data   head word, first-word-fall-through, 0 while empty
//   empty       no packet stored
//   level       stored packets, 0..DEPTH
//   overflow    sticky push-while-full   (NIC_FIFO_ERR_EN only)
//   underflow   sticky pop-while-empty   (NIC_FIFO_ERR_EN only)
// ---------------------------------------------------------------------------
module nic_width_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          aclk,
    input  logic          reset,
    input  logic          write_en,
    input  logic [63:0]   write_data,
    output logic          full,
    input  logic          read_en,
    output logic [31:0]   read_data,
    output logic          empty,
    output logic [AW:0]   level
`ifdef NIC_FIFO_ERR_EN
    ,
    output logic          overflow,
    output logic          underflow
`endif
);

    logic [63:0] mem [DEPTH];

    // The extra MSB on each pointer is the wrap bit; it lets level reach
    // DEPTH without being confused with 0.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Half select: 0 = next pop returns the address word,
    // 1 = next pop returns the payload word and retires the packet.
    logic        hsel;

    logic        push_ok;
    logic        pop_ok;

    assign level = wr_ptr - rd_ptr;
    assign empty = (level == '0);
    assign full  = (level == (AW+1)'(DEPTH));

    assign push_ok = write_en && !full;
    assign pop_ok  = read_en && !empty;

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge aclk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= write_data;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            hsel   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop_ok) begin
                if (hsel) begin
                    // Second word leaves: only now is the slot released,
                    // so full and level move on this edge, not the first.
                    hsel   <= 1'b0;
                    rd_ptr <= rd_ptr + (AW+1)'(1);
                end else begin
                    hsel   <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        read_data = 32'h0;
        if (!empty) begin
            read_data = hsel ? mem[rd_ptr[AW-1:0]][31:0]
                             : mem[rd_ptr[AW-1:0]][63:32];
        end
    end

`ifdef NIC_FIFO_ERR_EN
    always_ff @(posedge aclk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_en && full) begin
                overflow <= 1'b1;
            end
            if (read_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule
